// File: rtl/bicubic_stream_ctrl_if.sv
// Stream, core-drive and output-tag bundle between the bicubic frame sequencer and its neighbours.
interface bicubic_stream_ctrl_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        core_act;
  logic [7:0]  core_in;
  logic [1:0]  core_phase;
  logic        o_valid;
  logic [15:0] o_row;
  logic [15:0] o_col;
  logic        o_eof;

  modport master (output s_valid, s_data,
                  input  s_ready, core_act, core_in, core_phase, o_valid, o_row, o_col, o_eof);
  modport slave  (input  s_valid, s_data,
                  output s_ready, core_act, core_in, core_phase, o_valid, o_row, o_col, o_eof);
endinterface

// File: rtl/bicubic_stream_ctrl.sv
// Frame sequencer for the bicubic core: feeds pixels, primes/flushes the 4-tap window, tags outputs.
// Optional stall watchdog enabled by defining BICUBIC_CTRL_STALL_WDT_EN.
module bicubic_stream_ctrl #(
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int CORE_LAT  = 6,
  parameter int PRIME_N   = 3,
  parameter int STALL_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  bicubic_stream_ctrl_if.slave bus,
  output logic busy,
  output logic frame_done,
  output logic err_stall
);
  localparam int TOTAL = IMG_W * IMG_H;
  // Stages ahead of the o_valid register; together they span CORE_LAT cycles.
  localparam int LW = CORE_LAT - 1;

  typedef enum logic [2:0] {IDLE, FEED, FLUSH, WAIT, DONE} state_t;

  state_t          state_r, state_s;
  logic [15:0]     in_row_r, in_col_r, orow_cnt_r, ocol_cnt_r, o_row_r, o_col_r;
  logic [31:0]     pix_cnt_r, out_cnt_r, flush_cnt_r, act_cnt_r;
  logic [7:0]      last_pix_r;
  logic [1:0]      phase_r;
  logic [LW-1:0]   act_sr_r, disc_sr_r;
  logic            o_valid_r, o_eof_r;
  logic            hs_s, act_s, start_acc_s, last_acc_s, stall_hit_s, wait_exit_s;
  logic            valid_next_s, eof_hit_s, disc_s;

  assign start_acc_s  = (state_r == IDLE) && start;
  assign hs_s         = (state_r == FEED) && bus.s_valid;
  assign act_s        = hs_s || (state_r == FLUSH);
  assign last_acc_s   = hs_s && (in_row_r == 16'(IMG_H - 1)) && (in_col_r == 16'(IMG_W - 1));
  assign disc_s       = (act_cnt_r < 32'(PRIME_N));
  assign valid_next_s = act_sr_r[LW-1] && !disc_sr_r[LW-1];
  assign eof_hit_s    = ((out_cnt_r + 32'd1) == pix_cnt_r);

  assign bus.s_ready    = (state_r == FEED);
  assign bus.core_act   = act_s;
  assign bus.core_in    = hs_s ? bus.s_data : last_pix_r;
  assign bus.core_phase = phase_r;
  assign bus.o_valid    = o_valid_r;
  assign bus.o_row      = o_row_r;
  assign bus.o_col      = o_col_r;
  assign bus.o_eof      = o_eof_r;
  assign busy           = (state_r != IDLE);
  assign frame_done     = (state_r == DONE);

`ifdef BICUBIC_CTRL_STALL_WDT_EN
  logic [15:0] stall_cnt_r;
  logic        err_stall_r;

  assign stall_hit_s = (state_r == FEED) && !bus.s_valid && (stall_cnt_r == 16'(STALL_MAX - 1));
  // A truncated frame has no fixed output count, so drain until the delay line is empty.
  assign wait_exit_s = (act_sr_r == {LW{1'b0}});
  assign err_stall   = err_stall_r;

  // Consecutive-stall watchdog with sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'd0;
      err_stall_r <= 1'b0;
    end else if (start_acc_s) begin
      stall_cnt_r <= 16'd0;
      err_stall_r <= 1'b0;
    end else begin
      if (state_r == FEED && !bus.s_valid) stall_cnt_r <= stall_cnt_r + 16'd1;
      else                                 stall_cnt_r <= 16'd0;
      if (stall_hit_s) err_stall_r <= 1'b1;
    end
  end
`else
  assign stall_hit_s = 1'b0;
  assign wait_exit_s = (out_cnt_r == 32'(TOTAL));
  assign err_stall   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = FEED; else state_s = IDLE;
      FEED:    if (last_acc_s || stall_hit_s) state_s = FLUSH; else state_s = FEED;
      FLUSH:   if (flush_cnt_r == 32'(PRIME_N - 1)) state_s = WAIT; else state_s = FLUSH;
      WAIT:    if (wait_exit_s) state_s = DONE; else state_s = WAIT;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Input raster, flush and act-index counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_row_r <= 16'd0; in_col_r <= 16'd0; pix_cnt_r <= 32'd0;
      last_pix_r <= 8'd0; flush_cnt_r <= 32'd0; act_cnt_r <= 32'd0;
    end else if (start_acc_s) begin
      in_row_r <= 16'd0; in_col_r <= 16'd0; pix_cnt_r <= 32'd0;
      last_pix_r <= 8'd0; flush_cnt_r <= 32'd0; act_cnt_r <= 32'd0;
    end else begin
      if (hs_s) begin
        last_pix_r <= bus.s_data;
        pix_cnt_r  <= pix_cnt_r + 32'd1;
        if (in_col_r == 16'(IMG_W - 1)) begin
          in_col_r <= 16'd0;
          in_row_r <= in_row_r + 16'd1;
        end else begin
          in_col_r <= in_col_r + 16'd1;
        end
      end
      if (state_r == FLUSH) flush_cnt_r <= flush_cnt_r + 32'd1;
      else                  flush_cnt_r <= 32'd0;
      if (act_s && disc_s) act_cnt_r <= act_cnt_r + 32'd1;
    end
  end

  // Mirror of the core's phase select; the core resets to phase 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       phase_r <= 2'd2;
    else if (act_s) phase_r <= phase_r + 2'd1;
    else            phase_r <= phase_r;
  end

  // Act/discard delay line and output tagging; the output register forms the last stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_sr_r <= {LW{1'b0}}; disc_sr_r <= {LW{1'b0}};
      o_valid_r <= 1'b0; o_eof_r <= 1'b0; o_row_r <= 16'd0; o_col_r <= 16'd0;
      orow_cnt_r <= 16'd0; ocol_cnt_r <= 16'd0; out_cnt_r <= 32'd0;
    end else begin
      act_sr_r[0]  <= act_s;
      disc_sr_r[0] <= disc_s;
      for (int i = 1; i < LW; i++) begin
        act_sr_r[i]  <= act_sr_r[i-1];
        disc_sr_r[i] <= disc_sr_r[i-1];
      end
      o_valid_r <= valid_next_s;
      o_eof_r   <= valid_next_s && eof_hit_s;
      if (start_acc_s) begin
        orow_cnt_r <= 16'd0; ocol_cnt_r <= 16'd0; out_cnt_r <= 32'd0;
      end else if (valid_next_s) begin
        o_row_r   <= orow_cnt_r;
        o_col_r   <= ocol_cnt_r;
        out_cnt_r <= out_cnt_r + 32'd1;
        if (ocol_cnt_r == 16'(IMG_W - 1)) begin
          ocol_cnt_r <= 16'd0;
          orow_cnt_r <= orow_cnt_r + 16'd1;
        end else begin
          ocol_cnt_r <= ocol_cnt_r + 16'd1;
        end
      end else begin
        out_cnt_r <= out_cnt_r;
      end
    end
  end
endmodule

// File: tb/tb_bicubic_stream_ctrl.sv
// Self-checking bench for bicubic_stream_ctrl: directed frames with a coordinate/timing scoreboard.
module tb_bicubic_stream_ctrl;
  localparam int IMG_W = 4, IMG_H = 2, CORE_LAT = 6, PRIME_N = 3;
`ifdef BICUBIC_CTRL_STALL_WDT_EN
  localparam int STALL_MAX = 5;
`else
  localparam int STALL_MAX = 255;
`endif

  typedef struct { logic [15:0] r; logic [15:0] c; logic eof; } exp_t;

  logic clk = 1'b0, rst, start, busy, frame_done, err_stall;
  int checks = 0, failures = 0;
  int cyc = 0, n_act, n_valid, n_done, frame_acts, frame_total, push_idx, eof_cyc;
  logic [15:0] tb_row, tb_col;
  logic [7:0]  exp_last;
  exp_t q[$];
  int   due_q[$];

  bicubic_stream_ctrl_if bus();

  bicubic_stream_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CORE_LAT(CORE_LAT),
                        .PRIME_N(PRIME_N), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .frame_done(frame_done), .err_stall(err_stall));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard/monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_t e;
      cyc++;
      if (bus.s_ready) check("act_on_handshake", 32'(bus.core_act), 32'(bus.s_valid));
      if (bus.core_act) begin
        n_act++;
        if (bus.s_ready) check("core_in_pix", 32'(bus.core_in), 32'(bus.s_data));
        else             check("core_in_flush", 32'(bus.core_in), 32'(exp_last));
        if (frame_acts >= PRIME_N) due_q.push_back(cyc + CORE_LAT);
        frame_acts++;
      end
      if (bus.s_ready && bus.s_valid) begin
        e.r = tb_row; e.c = tb_col; e.eof = (push_idx == frame_total - 1);
        q.push_back(e);
        push_idx++;
        exp_last = bus.s_data;
        if (tb_col == 16'(IMG_W - 1)) begin tb_col = 16'd0; tb_row++; end
        else tb_col++;
      end
      if (bus.o_valid) begin
        n_valid++;
        if (q.size() == 0 || due_q.size() == 0) begin
          check("valid_unexpected", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("o_row", 32'(bus.o_row), 32'(e.r));
          check("o_col", 32'(bus.o_col), 32'(e.c));
          check("o_eof", 32'(bus.o_eof), 32'(e.eof));
          check("valid_latency", 32'(cyc), 32'(due_q.pop_front()));
          if (bus.o_eof) eof_cyc = cyc;
        end
      end
      if (frame_done) begin
        n_done++;
        check("done_after_eof", 32'(cyc), 32'(eof_cyc + 1));
      end
    end
  end

  task automatic frame_begin(input int total);
    tb_row = 16'd0; tb_col = 16'd0; push_idx = 0; frame_acts = 0;
    n_act = 0; n_valid = 0; n_done = 0; frame_total = total; eof_cyc = -10;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] p, input bit gap);
    bit ok = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = p;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk); ok = bus.s_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    bus.s_valid = 1'b0;
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk); seen = frame_done;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; bus.s_valid = 1'b0; bus.s_data = 8'd0;
    frame_begin(8);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(bus.s_ready), 32'd0);
    check("rst_phase", 32'(bus.core_phase), 32'd2);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_core_in", 32'(bus.core_in), 32'd0);
    rst = 1'b1;

    // Frame A: continuous stream.
    frame_begin(8);
    pulse_start();
    for (int i = 0; i < 8; i++) send_pix(8'h10 + 8'(i), 1'b0);
    wait_done();
    @(posedge clk); #1;
    check("A_acts", 32'(n_act), 32'd11);
    check("A_valids", 32'(n_valid), 32'd8);
    check("A_done_cnt", 32'(n_done), 32'd1);
    check("A_phase", 32'(bus.core_phase), 32'd1);
    check("A_queue_empty", 32'(q.size()), 32'd0);
    check("A_idle", 32'(busy), 32'd0);

    // Frame B: back-to-back, gapped stream, spurious starts in FEED and WAIT.
    frame_begin(8);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) start = 1'b1;
      send_pix(8'h20 + 8'(i), 1'b1);
      start = 1'b0;
    end
    repeat (5) @(posedge clk);
    #1 check("B_in_wait", 32'(busy), 32'd1);
    start = 1'b1; @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (4) @(posedge clk);
    #1;
    check("B_acts", 32'(n_act), 32'd11);
    check("B_valids", 32'(n_valid), 32'd8);
    check("B_done_cnt", 32'(n_done), 32'd1);
    check("B_phase", 32'(bus.core_phase), 32'd0);
    check("B_idle", 32'(busy), 32'd0);

    // Reset mid-FEED drops everything in flight.
    frame_begin(8);
    pulse_start();
    for (int i = 0; i < 3; i++) send_pix(8'h30 + 8'(i), 1'b0);
    rst = 1'b0; #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ready", 32'(bus.s_ready), 32'd0);
    check("mid_act", 32'(bus.core_act), 32'd0);
    check("mid_phase", 32'(bus.core_phase), 32'd2);
    check("mid_valid", 32'(bus.o_valid), 32'd0);
    q.delete(); due_q.delete(); n_valid = 0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (CORE_LAT + 4) @(negedge clk);
    check("mid_no_valid", 32'(n_valid), 32'd0);

`ifdef BICUBIC_CTRL_STALL_WDT_EN
    // Watchdog truncates a stalled frame after three pixels.
    frame_begin(3);
    pulse_start();
    for (int i = 0; i < 3; i++) send_pix(8'h40 + 8'(i), 1'b0);
    wait_done();
    check("wdt_err", 32'(err_stall), 32'd1);
    check("wdt_acts", 32'(n_act), 32'd6);
    check("wdt_valids", 32'(n_valid), 32'd3);
    @(posedge clk); #1;
    frame_begin(8);
    pulse_start();
    check("wdt_err_clear", 32'(err_stall), 32'd0);
    rst = 1'b0; q.delete(); due_q.delete();
    @(posedge clk); #1 rst = 1'b1;
`else
    check("err_tied", 32'(err_stall), 32'd0);
`endif
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
